pxi_dma_arbiter: RTL and testbench
==================================

PXI_DMA_ARBITER -- requirements
Module: pxi_dma_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, the number of DMA read requesters (acquisition FIFOs).
REQ-002 SHALL have parameter WAIT_MAX, default 64, the maximum number of consecutive wait states before a burst is aborted.
REQ-003 SHALL have port LCLK, input, 1 bit: the local-bus clock; the only clock in the block.
REQ-004 SHALL have port RSTN, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port LHOLD, input, 1 bit: the bridge's local-bus hold request.
REQ-006 SHALL have port LHOLDA, output, 1 bit: hold acknowledge.
REQ-007 SHALL have port ADSN, input, 1 bit: address strobe, active-low.
REQ-008 SHALL have port BLASTN, input, 1 bit: last-beat strobe, active-low.
REQ-009 SHALL have port DMA_RD_N, input, 1 bit: decoded DMA read data phase, active-low.
REQ-010 SHALL have port REQ, input, NREQ bits: per-requester "burst data available".
REQ-011 SHALL have port FIFO_EMPTY, input, NREQ bits: per-requester FIFO empty flag.
REQ-012 SHALL have port GNT, output, NREQ bits: one-hot grant, all-zero when idle.
REQ-013 SHALL have port POP, output, NREQ bits: one-cycle read strobe to the granted FIFO.
REQ-014 SHALL have port READYN, output, 1 bit: data-beat ready to the bridge, active-low.
REQ-015 SHALL have port XFER_CNT, output, 16 bits: number of beats completed in the current or last burst.
REQ-016 SHALL have port ABORT, output, 1 bit: sticky wait-timeout flag.
REQ-017 SHALL have port ABORT_CLR, input, 1 bit: clears ABORT.

Function
REQ-018 SHALL drive LHOLDA as LHOLD registered by one LCLK cycle, so it rises one cycle after LHOLD rises and falls one cycle after LHOLD falls.
REQ-019 SHALL implement FSM states IDLE, ARB, WAIT_ADS, DATA, DONE.
REQ-020 IDLE->ARB SHALL occur when LHOLDA=1 and REQ!=0.
REQ-021 In ARB, SHALL set GNT one-hot to the first REQ bit set, searching round-robin from (last granted index + 1) mod NREQ, then go to WAIT_ADS; ARB SHALL take exactly one cycle.
REQ-022 WAIT_ADS->DATA SHALL occur on ADSN=0 sampled together with DMA_RD_N=0; XFER_CNT SHALL clear to 0 on that edge.
REQ-023 In DATA, when DMA_RD_N=0 and FIFO_EMPTY[g]=0 (g = granted index), SHALL assert READYN=0 and POP[g]=1 in the same cycle and increment XFER_CNT; otherwise READYN=1 and POP=0 (wait state).
REQ-024 DATA->DONE SHALL occur on a cycle where BLASTN=0 and READYN=0 (last beat accepted).
REQ-025 A count of WAIT_MAX consecutive wait states in DATA SHALL set ABORT and go to DONE with READYN=1 and no POP.
REQ-026 DONE SHALL last one cycle, clear GNT, record g as last granted, then go to IDLE.
REQ-027 LHOLD=0 in any non-IDLE state SHALL go to IDLE next cycle, clear GNT and POP, and leave the round-robin pointer unchanged.
REQ-028 REQ changes after ARB SHALL NOT alter GNT until DONE or IDLE.
REQ-029 POP SHALL never be asserted for a requester whose FIFO_EMPTY=1, and SHALL never have more than one bit set.
REQ-030 XFER_CNT SHALL saturate at 16'hFFFF (no wrap).
REQ-031 ABORT_CLR=1 SHALL clear ABORT unless a timeout occurs in the same cycle, in which case set wins.

Reset
REQ-032 On RSTN=0 at an LCLK edge: FSM=IDLE, LHOLDA=0, GNT=0, POP=0, READYN=1, XFER_CNT=0, ABORT=0, last granted index=NREQ-1 (first grant search starts at requester 0).
REQ-033 Reset asserted mid-burst SHALL take priority over all other transitions.

Structure
REQ-034 The FSM state encoding and the WAIT_MAX default SHALL live in the shared package pxi_pkg.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and last pointer; outputs one-hot grant and index).

Verification
REQ-036 Single requester: REQ=4'b0001, LHOLD=1, ADSN/DMA_RD_N low, 8 beats with BLASTN low on the 8th -> LHOLDA one cycle after LHOLD, GNT=0001, 8 POP[0] pulses, XFER_CNT=8.
REQ-037 Round-robin: REQ=4'b1111 for four consecutive bursts -> grant order 0,1,2,3, then 0 on the fifth burst.
REQ-038 Empty mid-burst: FIFO_EMPTY[0]=1 for 3 cycles -> READYN=1 and POP=0 for those 3 cycles, burst resumes, final XFER_CNT unchanged from the requested length.
REQ-039 Timeout: FIFO_EMPTY[g] held at 1 for 64 cycles -> ABORT=1, FSM back in IDLE within 2 cycles; ABORT_CLR -> ABORT=0.
REQ-040 LHOLD dropped mid-DATA -> GNT=0 and POP=0 next cycle; the next arbitration regrants the same requester.
REQ-041 RSTN=0 mid-burst -> all outputs at their REQ-032 values after one edge.

Source files
------------

// File: rtl/pxi_pkg.sv
// Shared definitions for the PXI local-bus DMA read arbiter.
// Holds the burst FSM encoding and the default wait-state timeout.
package pxi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARB      = 3'd1,
    WAIT_ADS = 3'd2,
    DATA     = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int unsigned WAIT_MAX_DEFAULT = 64;
  localparam logic [15:0] XFER_CNT_MAX     = 16'hFFFF;

endpackage

// File: rtl/pxi_dma_arbiter_rr.sv
// Round-robin requester selection: the first set request after the
// previously granted index wins, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   index,
  output logic            valid
);

  always_comb begin
    index = '0;
    valid = 1'b0;
    // Scan from the farthest candidate to the nearest so the nearest one sticks.
    for (int k = NREQ; k >= 1; k--) begin
      if (req[IW'((int'(last) + k) % NREQ)]) begin
        index = IW'((int'(last) + k) % NREQ);
        valid = 1'b1;
      end
    end
    grant = valid ? (NREQ'(1) << index) : '0;
  end

endmodule

// File: rtl/pxi_dma_arbiter.sv
// Arbitrates PXI local-bus DMA reads among NREQ acquisition FIFOs, pacing
// beats with READYN and popping only the granted FIFO when it has data.
module pxi_dma_arbiter
  import pxi_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic            LCLK,
  input  logic            RSTN,
  input  logic            LHOLD,
  output logic            LHOLDA,
  input  logic            ADSN,
  input  logic            BLASTN,
  input  logic            DMA_RD_N,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] FIFO_EMPTY,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] POP,
  output logic            READYN,
  output logic [15:0]     XFER_CNT,
  output logic            ABORT,
  input  logic            ABORT_CLR
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(WAIT_MAX + 1);

  state_t          state;
  logic            lholda_q;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   last_idx;
  logic [15:0]     xfer_cnt_q;
  logic            abort_q;
  logic [WW-1:0]   wait_cnt;

  logic [NREQ-1:0] rr_grant;
  logic [IW-1:0]   rr_index;
  logic            rr_valid;

  logic            beat;
  logic            timeout;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req   (REQ),
    .last  (last_idx),
    .grant (rr_grant),
    .index (rr_index),
    .valid (rr_valid)
  );

  // A beat needs the bridge reading and the granted FIFO holding data; the
  // bridge samples READYN in the same cycle, so this path stays combinational.
  assign beat    = (state == DATA) && !DMA_RD_N && !FIFO_EMPTY[gnt_idx];
  assign timeout = (state == DATA) && !beat && LHOLD &&
                   (wait_cnt == WW'(WAIT_MAX - 1));

  assign READYN   = !beat;
  assign POP      = beat ? gnt_q : '0;
  assign LHOLDA   = lholda_q;
  assign GNT      = gnt_q;
  assign XFER_CNT = xfer_cnt_q;
  assign ABORT    = abort_q;

  always_ff @(posedge LCLK) begin
    if (!RSTN) begin
      state      <= IDLE;
      lholda_q   <= 1'b0;
      gnt_q      <= '0;
      gnt_idx    <= '0;
      last_idx   <= IW'(NREQ - 1);
      xfer_cnt_q <= '0;
      abort_q    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      lholda_q <= LHOLD;

      // A timeout in the same cycle as a clear request must win.
      if (ABORT_CLR) abort_q <= 1'b0;
      if (timeout)   abort_q <= 1'b1;

      if (beat && (xfer_cnt_q != XFER_CNT_MAX)) begin
        xfer_cnt_q <= xfer_cnt_q + 16'd1;
      end

      if ((state != IDLE) && !LHOLD) begin
        state <= IDLE;
        gnt_q <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (lholda_q && (REQ != '0)) state <= ARB;
          end
          ARB: begin
            if (rr_valid) begin
              gnt_q   <= rr_grant;
              gnt_idx <= rr_index;
              state   <= WAIT_ADS;
            end else begin
              state <= IDLE;
            end
          end
          WAIT_ADS: begin
            if (!ADSN && !DMA_RD_N) begin
              xfer_cnt_q <= '0;
              wait_cnt   <= '0;
              state      <= DATA;
            end
          end
          DATA: begin
            if (beat) begin
              wait_cnt <= '0;
              if (!BLASTN) state <= DONE;
            end else if (timeout) begin
              state <= DONE;
            end else begin
              wait_cnt <= wait_cnt + WW'(1);
            end
          end
          DONE: begin
            gnt_q    <= '0;
            last_idx <= gnt_idx;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pxi_dma_arbiter.sv
// Self-checking bench for pxi_dma_arbiter: directed bursts, timeouts, hold
// loss and reset, plus randomized bursts against a round-robin model.
module tb_pxi_dma_arbiter;

  localparam int NREQ     = 4;
  localparam int WAIT_MAX = 64;

  logic            LCLK = 1'b0;
  logic            RSTN;
  logic            LHOLD;
  logic            LHOLDA;
  logic            ADSN;
  logic            BLASTN;
  logic            DMA_RD_N;
  logic [NREQ-1:0] REQ;
  logic [NREQ-1:0] FIFO_EMPTY;
  logic [NREQ-1:0] GNT;
  logic [NREQ-1:0] POP;
  logic            READYN;
  logic [15:0]     XFER_CNT;
  logic            ABORT;
  logic            ABORT_CLR;

  int errors  = 0;
  int checks  = 0;
  int lastIdx = NREQ - 1;

  always #5 LCLK = ~LCLK;

  pxi_dma_arbiter #(
    .NREQ     (NREQ),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .LCLK       (LCLK),
    .RSTN       (RSTN),
    .LHOLD      (LHOLD),
    .LHOLDA     (LHOLDA),
    .ADSN       (ADSN),
    .BLASTN     (BLASTN),
    .DMA_RD_N   (DMA_RD_N),
    .REQ        (REQ),
    .FIFO_EMPTY (FIFO_EMPTY),
    .GNT        (GNT),
    .POP        (POP),
    .READYN     (READYN),
    .XFER_CNT   (XFER_CNT),
    .ABORT      (ABORT),
    .ABORT_CLR  (ABORT_CLR)
  );

  function automatic int onehot(input int i);
    return 1 << i;
  endfunction

  // First requester set after the last winner, wrapping around.
  function automatic int expGrant(input logic [NREQ-1:0] mask, input int last);
    logic [NREQ-1:0] sh;
    for (int k = 1; k <= NREQ; k++) begin
      sh = mask >> ((last + k) % NREQ);
      if (sh[0]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic stepClk();
    @(posedge LCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " lholda"}, 32'(LHOLDA), 0);
    checkOutput({tag, " gnt"}, 32'(GNT), 0);
    checkOutput({tag, " pop"}, 32'(POP), 0);
    checkOutput({tag, " readyn"}, 32'(READYN), 1);
    checkOutput({tag, " xfer_cnt"}, 32'(XFER_CNT), 0);
    checkOutput({tag, " abort"}, 32'(ABORT), 0);
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] mask, output int idx);
    int n = 0;
    idx = expGrant(mask, lastIdx);
    REQ = mask;
    while (GNT == '0 && n < 8) begin
      stepClk();
      n++;
    end
    checkOutput("arb latency", n, 2);
    checkOutput("grant", 32'(GNT), onehot(idx));
    REQ      = NREQ'($urandom);
    ADSN     = 1'b0;
    DMA_RD_N = 1'b0;
    #1;
    checkOutput("readyn wait_ads", 32'(READYN), 1);
    stepClk();
    ADSN = 1'b1;
    checkOutput("xfer clear", 32'(XFER_CNT), 0);
    checkOutput("gnt after ads", 32'(GNT), onehot(idx));
  endtask

  task automatic dataPhase(input int idx, input int len, input int stallBeat,
                           input int stallLen, input bit rdWaits);
    int beats = 0;
    int stalled = 0;
    int popCount = 0;
    bit stall;
    bit rdWait;
    bit expBeat;
    logic [NREQ-1:0] gntMask;
    gntMask = NREQ'(onehot(idx));
    for (int cyc = 0; cyc < 400 && beats < len; cyc++) begin
      stall      = (beats == stallBeat) && (stalled < stallLen);
      rdWait     = rdWaits && !stall && ($urandom_range(0, 3) == 0);
      expBeat    = !stall && !rdWait;
      REQ        = NREQ'($urandom);
      DMA_RD_N   = rdWait;
      FIFO_EMPTY = (NREQ'($urandom) & ~gntMask) | (stall ? gntMask : '0);
      BLASTN     = (beats != len - 1);
      #1;
      checkOutput("readyn", 32'(READYN), 32'(!expBeat));
      checkOutput("pop", 32'(POP), expBeat ? 32'(gntMask) : 0);
      checkOutput("gnt hold", 32'(GNT), 32'(gntMask));
      if ((POP & gntMask) != '0) popCount++;
      if (expBeat) beats++;
      if (stall) stalled++;
      stepClk();
    end
    REQ        = '0;
    DMA_RD_N   = 1'b1;
    BLASTN     = 1'b1;
    FIFO_EMPTY = '0;
    checkOutput("xfer cnt", 32'(XFER_CNT), len);
    checkOutput("pop count", popCount, len);
    stepClk();
    checkOutput("gnt idle", 32'(GNT), 0);
    lastIdx = idx;
  endtask

  task automatic runBurst(input logic [NREQ-1:0] mask, input int len, input int stallBeat,
                          input int stallLen, input bit rdWaits);
    int idx;
    applyStimulus(mask, idx);
    dataPhase(idx, len, stallBeat, stallLen, rdWaits);
  endtask

  task automatic runTimeout(input logic [NREQ-1:0] mask, input bit clrSame);
    int g;
    applyStimulus(mask, g);
    FIFO_EMPTY = NREQ'(onehot(g));
    DMA_RD_N   = 1'b0;
    BLASTN     = 1'b0;
    for (int i = 0; i < WAIT_MAX - 1; i++) stepClk();
    checkOutput("abort early", 32'(ABORT), 0);
    ABORT_CLR = clrSame;
    #1;
    checkOutput("timeout readyn", 32'(READYN), 1);
    checkOutput("timeout pop", 32'(POP), 0);
    stepClk();
    checkOutput("abort set", 32'(ABORT), 1);
    ABORT_CLR  = 1'b0;
    FIFO_EMPTY = '0;
    DMA_RD_N   = 1'b1;
    BLASTN     = 1'b1;
    REQ        = '0;
    checkOutput("timeout xfer", 32'(XFER_CNT), 0);
    stepClk();
    checkOutput("timeout idle gnt", 32'(GNT), 0);
    lastIdx = g;
    if (!clrSame) begin
      ABORT_CLR = 1'b1;
      stepClk();
      ABORT_CLR = 1'b0;
      checkOutput("abort clear", 32'(ABORT), 0);
    end
  endtask

  initial begin
    int g;
    RSTN       = 1'b0;
    LHOLD      = 1'b0;
    ADSN       = 1'b1;
    BLASTN     = 1'b1;
    DMA_RD_N   = 1'b1;
    ABORT_CLR  = 1'b0;
    REQ        = '0;
    FIFO_EMPTY = '0;
    repeat (2) stepClk();
    checkResetState("reset");

    RSTN  = 1'b1;
    LHOLD = 1'b1;
    #1;
    checkOutput("lholda lag", 32'(LHOLDA), 0);
    stepClk();
    checkOutput("lholda rise", 32'(LHOLDA), 1);

    // Single requester, eight beats.
    runBurst(4'b0001, 8, 99, 0, 1'b0);
    // Granted FIFO runs dry for three cycles mid-burst.
    runBurst(4'b0001, 6, 2, 3, 1'b0);
    // Timeout with a simultaneous clear request: the set must win.
    runTimeout(4'b0110, 1'b1);

    // Reset in the middle of a burst while ABORT is still set.
    applyStimulus(4'b1111, g);
    FIFO_EMPTY = '0;
    DMA_RD_N   = 1'b0;
    BLASTN     = 1'b1;
    repeat (3) stepClk();
    RSTN = 1'b0;
    stepClk();
    checkResetState("mid-burst reset");
    RSTN     = 1'b1;
    DMA_RD_N = 1'b1;
    REQ      = '0;
    lastIdx  = NREQ - 1;
    stepClk();
    checkOutput("lholda after reset", 32'(LHOLDA), 1);

    // Five bursts with everyone requesting: order 0,1,2,3,0.
    for (int b = 0; b < 5; b++) runBurst(4'b1111, 3, 99, 0, 1'b0);

    // Hold dropped mid-DATA; the next arbitration must pick the same requester.
    applyStimulus(4'b1111, g);
    DMA_RD_N   = 1'b0;
    FIFO_EMPTY = '0;
    repeat (2) stepClk();
    DMA_RD_N = 1'b1;
    LHOLD    = 1'b0;
    stepClk();
    checkOutput("drop gnt", 32'(GNT), 0);
    checkOutput("drop lholda", 32'(LHOLDA), 0);
    DMA_RD_N = 1'b0;
    #1;
    checkOutput("drop pop", 32'(POP), 0);
    checkOutput("drop readyn", 32'(READYN), 1);
    DMA_RD_N = 1'b1;
    LHOLD    = 1'b1;
    REQ      = '0;
    stepClk();
    checkOutput("regain lholda", 32'(LHOLDA), 1);
    checkOutput("regrant model", expGrant(4'b1111, lastIdx), g);
    runBurst(4'b1111, 4, 99, 0, 1'b0);

    // Timeout followed by an explicit clear.
    runTimeout(4'b1000, 1'b0);

    for (int r = 0; r < 8; r++) begin
      runBurst(NREQ'($urandom_range(1, 15)), int'($urandom_range(1, 10)),
               int'($urandom_range(0, 9)), int'($urandom_range(0, 6)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
